// File: rtl/hangman_engine.sv
// hangman_engine -- letter-guessing game engine.
//
// A secret word of WORD_LEN letters is latched on word_load. Each accepted
// guess is compared against the word one position per cycle; positions that
// match are revealed in index_correct. A guess that matches nowhere costs a
// miss. The game ends in DONE on a full reveal (win) or when miss_cnt reaches
// MAX_MISS (lose).
//
// Optional feature: define HANGMAN_REPEAT_GUARD_EN to keep a set of letters
// already tried. A repeated guess then skips the scan and is scored at once
// with repeat_flag=1 and no counter change. Without the macro, repeats are
// scanned like any other guess and repeat_flag is tied 0.
//
// Handshake: a guess transfers on a rising clk edge where guess_valid and
// guess_ready are both 1. guess_ready is 1 only in IDLE and is dropped while
// word_load is high, so a guess offered with word_load is never transferred.
//
// Ports:
//   clk, nRst            clock (rising edge), asynchronous active-low reset
//   word_in, word_load   secret word (letter 0 in the MSBs), load pulse
//   guess, guess_valid   guessed letter offer
//   guess_ready          engine accepts a guess this cycle
//   letter               last accepted guess
//   index_correct        bit i set = letter i revealed
//   correct_cnt          popcount of index_correct
//   miss_cnt             misses so far (saturates at MAX_MISS)
//   result_valid         one-cycle pulse when a guess is scored
//   hit, miss            scoring outcome, qualified by result_valid
//   repeat_flag          guess already tried, qualified by result_valid
//   win, lose            game-over levels
//   busy                 scan in progress
//   dbg_state            current FSM state (SET=0 IDLE=1 SCAN=2 SCORE=3 DONE=4)
module hangman_engine #(
    parameter int WORD_LEN = 5,
    parameter int CHAR_W   = 8,
    parameter int MAX_MISS = 6
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic [WORD_LEN*CHAR_W-1:0]      word_in,
    input  logic                            word_load,
    input  logic [CHAR_W-1:0]               guess,
    input  logic                            guess_valid,
    output logic                            guess_ready,
    output logic [CHAR_W-1:0]               letter,
    output logic [WORD_LEN-1:0]             index_correct,
    output logic [$clog2(WORD_LEN+1)-1:0]   correct_cnt,
    output logic [$clog2(MAX_MISS+1)-1:0]   miss_cnt,
    output logic                            result_valid,
    output logic                            hit,
    output logic                            miss,
    output logic                            repeat_flag,
    output logic                            win,
    output logic                            lose,
    output logic                            busy,
    output logic [2:0]                      dbg_state
);

    localparam int IDX_W  = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam int CNT_W  = $clog2(WORD_LEN + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_LEN - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISS);

    typedef enum logic [2:0] {
        SET   = 3'd0,
        IDLE  = 3'd1,
        SCAN  = 3'd2,
        SCORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [WORD_LEN*CHAR_W-1:0]     word_q, word_d;
    logic [CHAR_W-1:0]              letter_q, letter_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [WORD_LEN-1:0]            ic_q, ic_d;
    logic [MISS_W-1:0]              miss_q, miss_d;
    logic                           hit_q, hit_d;
    logic [CHAR_W-1:0]              cur_letter;
    logic [MISS_W-1:0]              miss_upd;
    logic                           is_rep;

`ifdef HANGMAN_REPEAT_GUARD_EN
    logic [(1<<CHAR_W)-1:0]         tried_q, tried_d;
    logic                           rep_q, rep_d;
    assign is_rep = rep_q;
`else
    assign is_rep = 1'b0;
`endif

    // Letter under the scan pointer; letter 0 lives in the MSBs of the word.
    always_comb begin
        cur_letter = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (idx_q == IDX_W'(i)) cur_letter = word_q[(WORD_LEN-1-i)*CHAR_W +: CHAR_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        letter_d = letter_q;
        idx_d    = idx_q;
        ic_d     = ic_q;
        miss_d   = miss_q;
        hit_d    = hit_q;
        miss_upd = miss_q;
`ifdef HANGMAN_REPEAT_GUARD_EN
        tried_d  = tried_q;
        rep_d    = rep_q;
`endif
        if (word_load) begin
            // A load from any state restarts the game and abandons any scan.
            state_d = IDLE;
            word_d  = word_in;
            idx_d   = '0;
            ic_d    = '0;
            miss_d  = '0;
            hit_d   = 1'b0;
`ifdef HANGMAN_REPEAT_GUARD_EN
            tried_d = '0;
            rep_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (guess_valid) begin
                        letter_d = guess;
                        idx_d    = '0;
                        hit_d    = 1'b0;
                        state_d  = SCAN;
`ifdef HANGMAN_REPEAT_GUARD_EN
                        rep_d = 1'b0;
                        if (tried_q[guess]) begin
                            rep_d   = 1'b1;
                            state_d = SCORE;
                        end else begin
                            tried_d[guess] = 1'b1;
                        end
`endif
                    end
                end
                SCAN: begin
                    // Already-revealed positions still count as a hit.
                    if (cur_letter == letter_q) begin
                        ic_d[idx_q] = 1'b1;
                        hit_d       = 1'b1;
                    end
                    if (idx_q == LAST_IDX) state_d = SCORE;
                    else                   idx_d   = idx_q + 1'b1;
                end
                SCORE: begin
                    if (!hit_q && !is_rep && miss_q != MISS_MAX) miss_upd = miss_q + 1'b1;
                    miss_d  = miss_upd;
                    state_d = (&ic_q || miss_upd == MISS_MAX) ? DONE : IDLE;
                end
                default: ;  // SET and DONE wait for word_load
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= SET;
            word_q   <= '0;
            letter_q <= '0;
            idx_q    <= '0;
            ic_q     <= '0;
            miss_q   <= '0;
            hit_q    <= 1'b0;
`ifdef HANGMAN_REPEAT_GUARD_EN
            tried_q  <= '0;
            rep_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            letter_q <= letter_d;
            idx_q    <= idx_d;
            ic_q     <= ic_d;
            miss_q   <= miss_d;
            hit_q    <= hit_d;
`ifdef HANGMAN_REPEAT_GUARD_EN
            tried_q  <= tried_d;
            rep_q    <= rep_d;
`endif
        end
    end

    always_comb begin
        correct_cnt = '0;
        for (int i = 0; i < WORD_LEN; i++) correct_cnt = correct_cnt + CNT_W'(ic_q[i]);
    end

    assign guess_ready   = (state_q == IDLE) && !word_load;
    assign letter        = letter_q;
    assign index_correct = ic_q;
    assign miss_cnt      = miss_q;
    assign result_valid  = (state_q == SCORE);
    assign hit           = result_valid && hit_q && !is_rep;
    assign miss          = result_valid && !hit_q && !is_rep;
    assign repeat_flag   = result_valid && is_rep;
    assign win           = &ic_q;
    assign lose          = (miss_q == MISS_MAX) && !win;
    assign busy          = (state_q == SCAN);
    assign dbg_state     = state_q;

endmodule
